// File: rtl/neuron_mac.sv
// neuron_mac: sequential multiply-accumulate engine for one neuron.
// It streams DEPTH weight/pixel pairs from a synchronous-read ROM and buffer,
// with one cycle of latency, and accumulates their products onto a signed bias.
// The ROM and the buffer share one address bus.
// The result optionally passes through a ReLU and is held behind a
// valid/ready handshake until the consumer accepts it.
module neuron_mac #(
  parameter int DEPTH     = 784,
  parameter int WIDTH     = 32,
  parameter int PIX_WIDTH = 8,
  parameter int ACC_WIDTH = 64,
  parameter int RELU      = 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic signed [WIDTH-1:0]     bias,
  output logic [$clog2(DEPTH)-1:0]    addr,
  input  logic signed [WIDTH-1:0]     weight,
  input  logic [PIX_WIDTH-1:0]        pixel,
  output logic                        busy,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic signed [ACC_WIDTH-1:0] out_data
);

  // Address width. DEPTH must be at least 2 so that the address bus has at least one bit.
  localparam int AW = $clog2(DEPTH);
  // Product width: a signed weight times a zero-extended (so non-negative) pixel.
  localparam int PW = WIDTH + PIX_WIDTH + 1;
  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    OUT
  } state_t;

  state_t                      state;
  logic                        acc_vld;   // weight/pixel on the inputs belong to the previous RUN address
  logic signed [ACC_WIDTH-1:0] acc;

  logic signed [PW-1:0]        prod;
  logic signed [ACC_WIDTH-1:0] prod_ext;
  logic signed [ACC_WIDTH-1:0] sum;
  logic signed [ACC_WIDTH-1:0] result;

  // Product of the current ROM/buffer data and the running sum that includes it.
  // The sum wraps modulo 2^ACC_WIDTH.
  // NOTE: every signal assigned in always_comb gets a value on every path, so no latch is inferred.
  always_comb begin
    prod     = weight * $signed({1'b0, pixel});
    prod_ext = {{(ACC_WIDTH - PW){prod[PW-1]}}, prod};
    sum      = acc + prod_ext;
    result   = sum;
    if ((RELU != 0) && sum[ACC_WIDTH-1]) begin
      result = '0;
    end
  end

  // Control FSM, address counter, accumulator and registered result/handshake.
  // addr doubles as the element counter and is held at 0 outside RUN.
  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      addr      <= '0;
      acc_vld   <= 1'b0;
      acc       <= '0;
      busy      <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      // Data arrives one cycle after its address, so the accumulate flag trails RUN by one cycle.
      acc_vld <= (state == RUN);
      if (acc_vld) begin
        acc <= sum;
      end

      case (state)
        IDLE: begin
          if (start) begin
            state <= RUN;
            busy  <= 1'b1;
            addr  <= '0;
            acc   <= {{(ACC_WIDTH - WIDTH){bias[WIDTH-1]}}, bias};
          end
        end
        RUN: begin
          if (addr == LAST_ADDR) begin
            state <= DRAIN;
            addr  <= '0;
          end else begin
            addr <= addr + 1'b1;
          end
        end
        DRAIN: begin
          // The last element is folded in here; the sum is captured in the same cycle.
          state     <= OUT;
          busy      <= 1'b0;
          out_valid <= 1'b1;
          out_data  <= result;
        end
        OUT: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_neuron_mac.sv
// tb_neuron_mac: directed checks of neuron_mac in three configurations.
// Two DEPTH=4 instances, one with ReLU and one without, share all of their stimulus.
// A third instance uses DEPTH=784 with ReLU.
module tb_neuron_mac;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               rst, start, start_c, out_ready;
  logic signed [31:0] bias;

  // DEPTH=4 pair: shared ROM model driven from instance a's address
  logic [1:0]         addr_a, addr_b;
  logic signed [31:0] weight4;
  logic [7:0]         pixel4;
  logic               busy_a, busy_b, valid_a, valid_b;
  logic signed [63:0] data_a, data_b;

  // DEPTH=784 instance
  logic [9:0]         addr_c;
  logic signed [31:0] weight_c;
  logic [7:0]         pixel_c;
  logic               busy_c, valid_c;
  logic signed [63:0] data_c;

  logic signed [31:0] w4 [4];
  logic [7:0]         p4 [4];
  logic               garble;

  int errors = 0;
  int checks = 0;

  neuron_mac #(.DEPTH(4), .RELU(1)) u_a (
    .clk(clk), .rst(rst), .start(start), .bias(bias), .addr(addr_a),
    .weight(weight4), .pixel(pixel4), .busy(busy_a), .out_valid(valid_a),
    .out_ready(out_ready), .out_data(data_a));

  neuron_mac #(.DEPTH(4), .RELU(0)) u_b (
    .clk(clk), .rst(rst), .start(start), .bias(bias), .addr(addr_b),
    .weight(weight4), .pixel(pixel4), .busy(busy_b), .out_valid(valid_b),
    .out_ready(out_ready), .out_data(data_b));

  neuron_mac #(.DEPTH(784), .RELU(1)) u_c (
    .clk(clk), .rst(rst), .start(start_c), .bias(bias), .addr(addr_c),
    .weight(weight_c), .pixel(pixel_c), .busy(busy_c), .out_valid(valid_c),
    .out_ready(out_ready), .out_data(data_c));

  // Synchronous-read ROM/buffer models.
  // When garble is set, any read that does not follow a busy cycle returns junk,
  // so data outside the accumulate window can be seen to have no effect.
  always @(posedge clk) begin
    if (garble && !busy_a) begin
      weight4 <= $urandom;
      pixel4  <= 8'($urandom);
    end else begin
      weight4 <= w4[addr_a];
      pixel4  <= p4[addr_a];
    end
    weight_c <= 32'(addr_c);
    pixel_c  <= 8'd1;
  end

  task automatic check(input string tag, input logic signed [63:0] got, input logic signed [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One DEPTH=4 operation on both instances.
  // The task checks the address sequence and the exact output latency.
  // hold > 0 keeps out_ready low for that many cycles and pulses start while the result waits.
  task automatic run_d4(input string tag, input logic signed [31:0] b, input int hold,
                        input logic signed [63:0] exp_a, input logic signed [63:0] exp_b);
    bias      = b;
    out_ready = (hold == 0);
    start     = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 4; k++) begin
      check($sformatf("%s_addr%0d", tag, k), addr_a, k);
      check($sformatf("%s_busy%0d", tag, k), busy_a, 1);
      if (garble) bias = $urandom;
      tick();
    end
    check({tag, "_drain_valid"}, valid_a, 0);
    tick();
    check({tag, "_valid_a"}, valid_a, 1);
    check({tag, "_valid_b"}, valid_b, 1);
    check({tag, "_data_a"}, data_a, exp_a);
    check({tag, "_data_b"}, data_b, exp_b);
    for (int h = 0; h < hold; h++) begin
      start = 1'b1;
      tick();
      check($sformatf("%s_hold_valid%0d", tag, h), valid_a, 1);
      check($sformatf("%s_hold_data%0d", tag, h), data_a, exp_a);
      check($sformatf("%s_hold_busy%0d", tag, h), busy_a, 0);
    end
    out_ready = 1'b1;
    tick();
    check({tag, "_done_valid"}, valid_a, 0);
    check({tag, "_done_busy"}, busy_a, 0);
    start = 1'b0;
  endtask

  initial begin
    int n;
    rst = 1'b1; start = 1'b0; start_c = 1'b0; out_ready = 1'b1; bias = '0; garble = 1'b0;
    for (int i = 0; i < 4; i++) begin
      w4[i] = i + 1;
      p4[i] = 8'd1;
    end
    tick();
    tick();
    rst = 1'b0;
    check("rst_busy", busy_a, 0);
    check("rst_valid", valid_a, 0);
    check("rst_data", data_a, 0);
    check("rst_addr", addr_a, 0);
    check("rst_addr_c", addr_c, 0);

    // Weights 1..4 with unit pixels: the sum is 10.
    run_d4("basic", 0, 0, 10, 10);

    // Weights of -1 with pixels of 255 and a bias of 100: 100 - 1020 = -920, which ReLU clamps to 0.
    for (int i = 0; i < 4; i++) begin
      w4[i] = -1;
      p4[i] = 8'd255;
    end
    run_d4("neg", 100, 0, 0, -920);

    // Backpressure: the result is held for 10 cycles while start pulses.
    // start is still high on the handshake edge and must be ignored there.
    for (int i = 0; i < 4; i++) begin
      w4[i] = i + 1;
      p4[i] = 8'd1;
    end
    run_d4("hold", 0, 10, 10, 10);
    // start on the next edge after returning to IDLE is accepted
    run_d4("after_hold", 0, 0, 10, 10);

    // Reset while addr is 2: the partial sum is dropped and no result appears.
    bias  = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    check("abort_addr_before", addr_a, 2);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_busy", busy_a, 0);
    check("abort_valid", valid_a, 0);
    check("abort_addr", addr_a, 0);
    for (int i = 0; i < 6; i++) tick();
    check("abort_no_valid", valid_a, 0);
    run_d4("post_abort", 0, 0, 10, 10);

    // Junk data outside the accumulate window and bias changes during RUN do not alter the result.
    garble = 1'b1;
    run_d4("garble", 0, 0, 10, 10);
    garble = 1'b0;

    // DEPTH=784 with weight[i]=i, unit pixels and a bias of -6: 306936 - 6 = 306930.
    // out_valid must rise on edge 785 after the start edge.
    bias      = -6;
    out_ready = 1'b1;
    start_c   = 1'b1;
    tick();
    start_c = 1'b0;
    bias    = 12345;
    n = 0;
    while (!valid_c && n < 900) begin
      tick();
      n++;
    end
    check("big_latency", n, 785);
    check("big_data", data_c, 306930);
    tick();
    check("big_done", valid_c, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
